// File: rtl/multi_cycle_control_if.sv
// Control bundle between the multi-cycle MIPS controller (master) and its datapath (slave).
interface multi_cycle_control_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCEn;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, Zero,
    output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, State
  );

  modport slave (
    output Opcode, Funct, Zero,
    input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, State
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS main controller: state sequencer plus combinational decode of control lines.
// Define MCC_ADDI_EN to enable addi (DECODE->ADDIEX->ADDIWB); otherwise addi runs as a no-op.
module multi_cycle_control (
  input logic                   CLK,
  input logic                   RST,
  multi_cycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d;
  logic   hold_q;

  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluctl, alu_funct;

  // hold_q keeps FETCH for one extra edge after reset is released.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FETCH;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d = FETCH;
    if (!hold_q) begin
      case (state_q)
        FETCH:  state_d = DECODE;
        DECODE: begin
          case (bus.Opcode)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_RTYPE:     state_d = EXEC;
            OP_BEQ:       state_d = BRANCH;
`ifdef MCC_ADDI_EN
            OP_ADDI:      state_d = ADDIEX;
`endif
            OP_J:         state_d = JUMP;
            default:      state_d = FETCH;
          endcase
        end
        MEMADR: state_d = (bus.Opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:  state_d = MEMWB;
        EXEC:   state_d = ALUWB;
`ifdef MCC_ADDI_EN
        ADDIEX: state_d = ADDIWB;
`endif
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    case (bus.Funct)
      6'b100000: alu_funct = 3'b010;
      6'b100010: alu_funct = 3'b110;
      6'b100100: alu_funct = 3'b000;
      6'b100101: alu_funct = 3'b001;
      6'b101010: alu_funct = 3'b111;
      default:   alu_funct = 3'b010;
    endcase
  end

  always_comb begin
    pcen     = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluctl   = 3'b000;
    pcsrc    = 2'b00;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        aluctl  = 3'b010;
        irwrite = 1'b1;
        pcen    = 1'b1;
      end
      DECODE: begin
        alusrcb = 2'b11;
        aluctl  = 3'b010;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluctl  = 3'b010;
      end
      MEMRD: iord = 1'b1;
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluctl  = alu_funct;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluctl  = 3'b110;
        pcsrc   = 2'b01;
        pcen    = bus.Zero;
      end
`ifdef MCC_ADDI_EN
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluctl  = 3'b010;
      end
      ADDIWB: regwrite = 1'b1;
`endif
      JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    // State is already FETCH while RST is high; only the write enables need masking.
    if (RST) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
    end
  end

  assign bus.PCEn       = pcen;
  assign bus.IorD       = iord;
  assign bus.MemWrite   = memwrite;
  assign bus.IRWrite    = irwrite;
  assign bus.RegDst     = regdst;
  assign bus.MemtoReg   = memtoreg;
  assign bus.RegWrite   = regwrite;
  assign bus.ALUSrcA    = alusrca;
  assign bus.ALUSrcB    = alusrcb;
  assign bus.ALUControl = aluctl;
  assign bus.PCSrc      = pcsrc;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: vector table, reset corner cases, randomized run against a sequence model.
module tb_multi_cycle_control;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_cycle_control_if bus();

  multi_cycle_control dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned exp_q[$];

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  // Output vector: {PCEn,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSrc}
  function automatic logic [14:0] pk(input logic pcen, input logic iord, input logic mw,
                                     input logic irw, input logic rd, input logic mtr,
                                     input logic rw, input logic a, input logic [1:0] b,
                                     input logic [2:0] c, input logic [1:0] p);
    return {pcen, iord, mw, irw, rd, mtr, rw, a, b, c, p};
  endfunction

  function automatic logic [14:0] got_out();
    return {bus.PCEn, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
            bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.PCSrc};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected control word for a state number, straight from the output table.
  function automatic logic [14:0] exp_out(input int unsigned st, input logic [5:0] f, input logic z);
    case (st)
      0:    return pk(1,0,0,1,0,0,0,0,2'b01,3'b010,2'b00);
      1:    return pk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00);
      2, 9: return pk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00);
      3:    return pk(0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00);
      4:    return pk(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00);
      5:    return pk(0,1,1,0,0,0,0,0,2'b00,3'b000,2'b00);
      6:    return pk(0,0,0,0,0,0,0,1,2'b00,alu_of(f),2'b00);
      7:    return pk(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00);
      8:    return pk(z,0,0,0,0,0,0,1,2'b00,3'b110,2'b01);
      10:   return pk(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00);
      11:   return pk(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b10);
      default: return '0;
    endcase
  endfunction

  // States visited after FETCH, ending with the return to FETCH.
  task automatic build_seq(input logic [5:0] op);
    case (op)
      LW:   exp_q = '{1, 2, 3, 4, 0};
      SW:   exp_q = '{1, 2, 5, 0};
      RT:   exp_q = '{1, 6, 7, 0};
      BEQ:  exp_q = '{1, 8, 0};
      JMP:  exp_q = '{1, 11, 0};
`ifdef MCC_ADDI_EN
      ADDI: exp_q = '{1, 9, 10, 0};
`endif
      default: exp_q = '{1, 0};
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z);
    bus.Opcode = op;
    bus.Funct  = f;
    bus.Zero   = z;
    build_seq(op);
    foreach (exp_q[i]) begin
      step();
      check($sformatf("seq op=%b state[%0d]", op, i), 32'(bus.State), exp_q[i]);
      check($sformatf("ctl op=%b state=%0d", op, exp_q[i]), 32'(got_out()),
            32'(exp_out(exp_q[i], f, z)));
    end
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int unsigned cpi;
    logic [3:0]  key_st;
    logic [14:0] key_out;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int unsigned cycles;
    logic        seen;
    logic [5:0]  ops[8];
    logic [5:0]  fns[6];

    rst        = 1'b1;
    bus.Opcode = LW;
    bus.Funct  = '0;
    bus.Zero   = 1'b0;
    #2;
    check("reset state", 32'(bus.State), 0);
    check("reset outputs", 32'(got_out()), 32'(pk(0,0,0,0,0,0,0,0,2'b01,3'b010,2'b00)));
    step();
    step();
    check("state held in reset", 32'(bus.State), 0);
    rst = 1'b0;
    step();
    check("first post-reset edge state", 32'(bus.State), 0);
    check("first post-reset outputs", 32'(got_out()), 32'(exp_out(0, '0, 1'b0)));
    run_instr(LW, 6'b000000, 1'b0);

    vecs = '{
      '{"lw memwb",   LW,  6'b000000, 1'b0, 5, 4'd4,  pk(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00)},
      '{"lw memadr",  LW,  6'b000000, 1'b0, 5, 4'd2,  pk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00)},
      '{"sw memwr",   SW,  6'b000000, 1'b0, 4, 4'd5,  pk(0,1,1,0,0,0,0,0,2'b00,3'b000,2'b00)},
      '{"r add",      RT,  6'b100000, 1'b0, 4, 4'd6,  pk(0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00)},
      '{"r sub",      RT,  6'b100010, 1'b0, 4, 4'd6,  pk(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b00)},
      '{"r and",      RT,  6'b100100, 1'b0, 4, 4'd6,  pk(0,0,0,0,0,0,0,1,2'b00,3'b000,2'b00)},
      '{"r or",       RT,  6'b100101, 1'b0, 4, 4'd6,  pk(0,0,0,0,0,0,0,1,2'b00,3'b001,2'b00)},
      '{"r slt",      RT,  6'b101010, 1'b0, 4, 4'd6,  pk(0,0,0,0,0,0,0,1,2'b00,3'b111,2'b00)},
      '{"r bad funct",RT,  6'b111111, 1'b0, 4, 4'd6,  pk(0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00)},
      '{"r aluwb",    RT,  6'b100000, 1'b0, 4, 4'd7,  pk(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00)},
      '{"beq taken",  BEQ, 6'b000000, 1'b1, 3, 4'd8,  pk(1,0,0,0,0,0,0,1,2'b00,3'b110,2'b01)},
      '{"beq not",    BEQ, 6'b000000, 1'b0, 3, 4'd8,  pk(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01)},
      '{"jump",       JMP, 6'b000000, 1'b0, 3, 4'd11, pk(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b10)},
`ifdef MCC_ADDI_EN
      '{"addi wb",    ADDI,6'b000000, 1'b0, 4, 4'd10, pk(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00)},
      '{"addi ex",    ADDI,6'b000000, 1'b0, 4, 4'd9,  pk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00)},
`else
      '{"addi nop",   ADDI,6'b000000, 1'b0, 2, 4'd1,  pk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00)},
`endif
      '{"unsupported",6'b111111, 6'b000000, 1'b0, 2, 4'd1, pk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00)}
    };

    foreach (vecs[v]) begin
      bus.Opcode = vecs[v].op;
      bus.Funct  = vecs[v].funct;
      bus.Zero   = vecs[v].zero;
      cycles = 0;
      seen   = 1'b0;
      do begin
        step();
        cycles++;
        if (bus.State == vecs[v].key_st && !seen) begin
          seen = 1'b1;
          check({vecs[v].name, " outputs"}, 32'(got_out()), 32'(vecs[v].key_out));
        end
      end while (bus.State != 4'd0 && cycles < 10);
      check({vecs[v].name, " key state reached"}, 32'(seen), 1);
      check({vecs[v].name, " cpi"}, cycles, vecs[v].cpi);
    end

    // Reset asserted mid-MEMWR of an sw, away from any clock edge.
    bus.Opcode = SW;
    step(); step(); step();
    check("sw reached memwr", 32'(bus.State), 5);
    check("memwrite before reset", 32'(bus.MemWrite), 1);
    #2 rst = 1'b1;
    #1;
    check("async reset state", 32'(bus.State), 0);
    check("async reset memwrite", 32'(bus.MemWrite), 0);
    check("async reset outputs", 32'(got_out()), 32'(pk(0,0,0,0,0,0,0,0,2'b01,3'b010,2'b00)));
    step();
    rst = 1'b0;
    step();
    check("post mid-reset hold state", 32'(bus.State), 0);
    run_instr(SW, 6'b000000, 1'b0);

    ops = '{LW, SW, RT, BEQ, ADDI, JMP, 6'b111111, 6'b010101};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ops[$urandom_range(7)];
      if ($urandom_range(7) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(5)];
      if ($urandom_range(3) == 0) fn = 6'($urandom);
      run_instr(op, fn, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
